// File: rtl/serial_link_pkg.sv
// Shared types for the serial link PHY TX scheduler: beat type, FSM states and the
// clock-divider/phase-shift configuration record with its legality check.
package serial_link_pkg;

    localparam int unsigned NumLanes = 8;
    // Width of one clock config field; matches $clog2(32)+1 for the default MaxClkDiv.
    localparam int unsigned PhyCfgW  = 6;

    typedef logic [2*NumLanes-1:0] phy_data_t;

    typedef enum logic [1:0] {StIdle, StSend, StGuard, StCfg} phy_sched_state_e;

    typedef struct packed {
        logic [PhyCfgW-1:0] clk_div;
        logic [PhyCfgW-1:0] shift_start;
        logic [PhyCfgW-1:0] shift_end;
    } phy_clk_cfg_t;

    function automatic logic phy_clk_cfg_valid(input phy_clk_cfg_t cfg);
        return (cfg.clk_div >= PhyCfgW'(2)) &&
               (cfg.shift_start < cfg.clk_div) &&
               (cfg.shift_end < cfg.clk_div) &&
               (cfg.shift_start != cfg.shift_end);
    endfunction

endpackage

// File: rtl/serial_link_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping around.
module serial_link_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic [31:0] k;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        k       = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = (32'(ptr_i) + i) % NumReq;
            if (!valid_o && req_i[IdxW'(k)]) begin
                idx_o   = IdxW'(k);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_link_phy_tx_sched.sv
// Shares the PHY TX channel between requesters with burst-granular round-robin, guard gaps
// and quiescent-only clock config updates. Optional stats: SERIAL_LINK_PHY_SCHED_STATS_EN.
module serial_link_phy_tx_sched #(
    parameter int unsigned NumReq        = 2,
    parameter type         phy_data_t    = serial_link_pkg::phy_data_t,
    parameter int unsigned MaxClkDiv     = 32,
    parameter int unsigned MaxBurst      = 16,
    parameter int unsigned GuardCycles   = 4,
    parameter int unsigned DefaultClkDiv = 8,
    parameter int unsigned CW            = $clog2(MaxClkDiv) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumReq-1:0]         req_valid_i,
    input  phy_data_t [NumReq-1:0]    req_data_i,
    input  logic [NumReq-1:0]         req_last_i,
    output logic [NumReq-1:0]         req_ready_o,
    output phy_data_t                 phy_data_o,
    output logic                      phy_valid_o,
    input  logic                      phy_ready_i,
    input  logic [CW-1:0]             cfg_clk_div_i,
    input  logic [CW-1:0]             cfg_shift_start_i,
    input  logic [CW-1:0]             cfg_shift_end_i,
    input  logic                      cfg_update_i,
    output logic                      cfg_busy_o,
    output logic                      cfg_err_o,
    input  logic                      cfg_err_clr_i,
    output logic [CW-1:0]             phy_clk_div_o,
    output logic [CW-1:0]             phy_clk_shift_start_o,
    output logic [CW-1:0]             phy_clk_shift_end_o,
`ifdef SERIAL_LINK_PHY_SCHED_STATS_EN
    output logic [NumReq-1:0][31:0]   stat_beats_o,
    input  logic                      stat_clr_i,
`endif
    output logic [$clog2(NumReq)-1:0] grant_id_o
);

    import serial_link_pkg::*;

    localparam int unsigned GW  = $clog2(NumReq);
    localparam int unsigned BCW = $clog2(MaxBurst + 1);
    localparam int unsigned GCW = $clog2(GuardCycles + 1);
    localparam phy_clk_cfg_t DefaultCfg = '{
        clk_div:     PhyCfgW'(DefaultClkDiv),
        shift_start: '0,
        shift_end:   PhyCfgW'(DefaultClkDiv / 2)
    };

    phy_sched_state_e state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic             pick_any;
    logic [BCW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GCW-1:0]   guard_cnt_q, guard_cnt_d;
    phy_clk_cfg_t     stage_q, stage_d, active_q, active_d;
    logic             pending_q, pending_d, err_q, err_d, err_set;
    logic             beat, burst_end;

    serial_link_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (GW)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_any)
    );

    // The granted requester is wired straight through; everyone else sees ready low.
    always_comb begin
        phy_valid_o = 1'b0;
        phy_data_o  = '0;
        req_ready_o = '0;
        if (state_q == StSend) begin
            phy_valid_o          = req_valid_i[grant_q];
            phy_data_o           = req_data_i[grant_q];
            req_ready_o[grant_q] = phy_ready_i;
        end
    end

    assign beat      = phy_valid_o & phy_ready_i;
    assign burst_end = beat & (req_last_i[grant_q] | (beat_cnt_q == BCW'(MaxBurst - 1)));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        guard_cnt_d = guard_cnt_q;
        stage_d     = stage_q;
        active_d    = active_q;
        pending_d   = pending_q;
        err_d       = err_q;
        err_set     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d = StCfg;
                end else if (pick_any) begin
                    grant_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (beat) beat_cnt_d = beat_cnt_q + 1'b1;
                if (burst_end) begin
                    rr_ptr_d    = GW'((32'(grant_q) + 32'd1) % NumReq);
                    guard_cnt_d = '0;
                    state_d     = StGuard;
                end
            end
            StGuard: begin
                if (guard_cnt_q == GCW'(GuardCycles - 1)) state_d = StIdle;
                else guard_cnt_d = guard_cnt_q + 1'b1;
            end
            StCfg: begin
                if (phy_clk_cfg_valid(stage_q)) active_d = stage_q;
                else err_set = 1'b1;
                pending_d   = 1'b0;
                guard_cnt_d = '0;
                state_d     = StGuard;
            end
            default: state_d = StIdle;
        endcase
        // A pulse landing in the CFG cycle re-arms pending with fresh staging.
        if (cfg_update_i) begin
            stage_d   = '{clk_div: cfg_clk_div_i, shift_start: cfg_shift_start_i,
                          shift_end: cfg_shift_end_i};
            pending_d = 1'b1;
        end
        if (err_set) err_d = 1'b1;
        else if (cfg_err_clr_i) err_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            guard_cnt_q <= '0;
            stage_q     <= DefaultCfg;
            active_q    <= DefaultCfg;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            stage_q     <= stage_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

    assign cfg_busy_o            = pending_q;
    assign cfg_err_o             = err_q;
    assign grant_id_o            = grant_q;
    assign phy_clk_div_o         = active_q.clk_div;
    assign phy_clk_shift_start_o = active_q.shift_start;
    assign phy_clk_shift_end_o   = active_q.shift_end;

`ifdef SERIAL_LINK_PHY_SCHED_STATS_EN
    logic [NumReq-1:0][31:0] stat_q, stat_d;

    // Clear wins over a coincident beat; counters saturate at all-ones.
    always_comb begin
        stat_d = stat_q;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (stat_clr_i) stat_d[i] = '0;
            else if (beat && (grant_q == GW'(i)) && (stat_q[i] != '1)) stat_d[i] = stat_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stat_q <= '0;
        else stat_q <= stat_d;
    end

    assign stat_beats_o = stat_q;
`endif

endmodule

// File: tb/tb_serial_link_phy_tx_sched.sv
// Randomized bench for the PHY TX scheduler against a burst-level round-robin model.
`timescale 1ns/1ps
module tb_serial_link_phy_tx_sched;
    import serial_link_pkg::*;

    localparam int unsigned NumReq = 2;
    localparam int unsigned CW     = 6;

    logic                   clk, rst_n;
    logic [NumReq-1:0]      req_valid, req_last, req_ready;
    phy_data_t [NumReq-1:0] req_data;
    phy_data_t              phy_data;
    logic                   phy_valid, phy_ready;
    logic [CW-1:0]          cfg_div, cfg_start, cfg_end;
    logic                   cfg_update, cfg_busy, cfg_err, cfg_err_clr;
    logic [CW-1:0]          phy_div, phy_start, phy_end;
    logic                   grant_id;
`ifdef SERIAL_LINK_PHY_SCHED_STATS_EN
    logic [NumReq-1:0][31:0] stat_beats;
    logic                    stat_clr;
    initial stat_clr = 1'b0;
`endif

    serial_link_phy_tx_sched dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .req_valid_i           (req_valid),
        .req_data_i            (req_data),
        .req_last_i            (req_last),
        .req_ready_o           (req_ready),
        .phy_data_o            (phy_data),
        .phy_valid_o           (phy_valid),
        .phy_ready_i           (phy_ready),
        .cfg_clk_div_i         (cfg_div),
        .cfg_shift_start_i     (cfg_start),
        .cfg_shift_end_i       (cfg_end),
        .cfg_update_i          (cfg_update),
        .cfg_busy_o            (cfg_busy),
        .cfg_err_o             (cfg_err),
        .cfg_err_clr_i         (cfg_err_clr),
        .phy_clk_div_o         (phy_div),
        .phy_clk_shift_start_o (phy_start),
        .phy_clk_shift_end_o   (phy_end),
`ifdef SERIAL_LINK_PHY_SCHED_STATS_EN
        .stat_beats_o          (stat_beats),
        .stat_clr_i            (stat_clr),
`endif
        .grant_id_o            (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nerr = 0;
    int model_ptr = 0;

    // Per-requester pending beats: {last, data}.
    logic [16:0] rq [2][$];
    logic [15:0] exp_data[$];
    int          exp_gid[$];
    bit          exp_first[$];
    logic [15:0] obs_data[$];
    int          obs_gid[$];
    int          obs_cyc[$];
    logic        log_busy[$];
    logic        log_rdy1[$];
    logic [17:0] log_cfg[$];

    task automatic add_burst(input int r, input int len, inout int seq);
        for (int k = 0; k < len; k++) begin
            rq[r].push_back({(k == len - 1), 4'(r), 12'(seq)});
            seq++;
        end
    endtask

    // Burst-level model: round-robin among requesters holding data, MaxBurst=16 split.
    task automatic build_expected();
        int pos [2];
        int r, n;
        bit done;
        logic [16:0] w;
        pos[0] = 0;
        pos[1] = 0;
        exp_data.delete();
        exp_gid.delete();
        exp_first.delete();
        while (pos[0] < rq[0].size() || pos[1] < rq[1].size()) begin
            r = model_ptr;
            if (pos[r] >= rq[r].size()) r = 1 - r;
            n = 0;
            done = 1'b0;
            while (!done) begin
                w = rq[r][pos[r]];
                exp_data.push_back(w[15:0]);
                exp_gid.push_back(r);
                exp_first.push_back(n == 0);
                n++;
                pos[r]++;
                done = w[16] || (n == 16) || (pos[r] >= rq[r].size());
            end
            model_ptr = (r + 1) % 2;
        end
    endtask

    // Drives requesters from rq until drained; rmode 0: ready=1, 1: toggle, 2: random.
    task automatic run_traffic(input int max_cyc, input int rmode, input int upd_cyc);
        int cyc = 0;
        int tail = 0;
        obs_data.delete(); obs_gid.delete(); obs_cyc.delete();
        log_busy.delete(); log_rdy1.delete(); log_cfg.delete();
        while (tail < 8 && cyc < max_cyc) begin
            for (int r = 0; r < 2; r++) begin
                req_valid[r] = rq[r].size() > 0;
                req_data[r]  = (rq[r].size() > 0) ? rq[r][0][15:0] : 16'h0;
                req_last[r]  = (rq[r].size() > 0) ? rq[r][0][16] : 1'b0;
            end
            phy_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 1)
                                             : ($urandom_range(0, 3) != 0);
            cfg_update = (cyc == upd_cyc);
            @(negedge clk);
            log_busy.push_back(cfg_busy);
            log_rdy1.push_back(req_ready[1]);
            log_cfg.push_back({phy_div, phy_start, phy_end});
            if (phy_valid && phy_ready) begin
                obs_data.push_back(phy_data);
                obs_gid.push_back(int'(grant_id));
                obs_cyc.push_back(cyc);
            end
            for (int r = 0; r < 2; r++)
                if (req_valid[r] && req_ready[r] && rq[r].size() > 0) void'(rq[r].pop_front());
            @(posedge clk);
            #1;
            cyc++;
            if (rq[0].size() == 0 && rq[1].size() == 0) tail++;
        end
        req_valid  = '0;
        req_last   = '0;
        cfg_update = 1'b0;
        if (tail < 8) begin
            nvec++; nerr++;
            $display("FAIL traffic_timeout: drained=%0d after %0d cycles, required drain", 0, cyc);
            rq[0].delete();
            rq[1].delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; req_last = '0; req_data = '0; phy_ready = 1'b1;
        cfg_div = '0; cfg_start = '0; cfg_end = '0; cfg_update = 1'b0; cfg_err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++; if (phy_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", phy_valid); end
        nvec++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rst_ready: got %b want 00", req_ready); end
        nvec++; if (phy_data !== 16'h0) begin nerr++; $display("FAIL rst_data: got %h want 0", phy_data); end
        nvec++; if ({cfg_busy, cfg_err, grant_id} !== 3'b000) begin
            nerr++; $display("FAIL rst_flags: got %b want 000", {cfg_busy, cfg_err, grant_id}); end
        nvec++; if ({phy_div, phy_start, phy_end} !== {6'd8, 6'd0, 6'd4}) begin
            nerr++; $display("FAIL rst_cfg: got %0d/%0d/%0d want 8/0/4", phy_div, phy_start, phy_end); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fairness();
        int seq = 0;
        for (int b = 0; b < 2; b++) begin
            add_burst(0, 3, seq);
            add_burst(1, 3, seq);
        end
        build_expected();
        run_traffic(300, 0, -1);
        nvec++; if (obs_data.size() !== exp_data.size()) begin
            nerr++; $display("FAIL fair_count: got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            nvec++; if (obs_data[i] !== exp_data[i] || obs_gid[i] !== exp_gid[i]) begin
                nerr++; $display("FAIL fair_beat[%0d]: got %h/g%0d want %h/g%0d",
                                 i, obs_data[i], obs_gid[i], exp_data[i], exp_gid[i]); end
            if (i > 0 && exp_first[i]) begin
                nvec++; if (obs_cyc[i] - obs_cyc[i-1] !== 6) begin
                    nerr++; $display("FAIL fair_gap[%0d]: got %0d want 6", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_max_burst();
        int seq = 0;
        add_burst(0, 40, seq);
        add_burst(1, 2, seq);
        add_burst(1, 2, seq);
        build_expected();
        run_traffic(500, 0, -1);
        nvec++; if (obs_data.size() !== 44) begin
            nerr++; $display("FAIL maxb_count: got %0d want 44", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            nvec++; if (obs_data[i] !== exp_data[i] || obs_gid[i] !== exp_gid[i]) begin
                nerr++; $display("FAIL maxb_beat[%0d]: got %h/g%0d want %h/g%0d",
                                 i, obs_data[i], obs_gid[i], exp_data[i], exp_gid[i]); end
            if (i > 0 && exp_first[i]) begin
                nvec++; if (obs_cyc[i] - obs_cyc[i-1] !== 6) begin
                    nerr++; $display("FAIL maxb_gap[%0d]: got %0d want 6", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        if (obs_gid.size() > 34) begin
            nvec++; if (obs_gid[16] !== 1 || obs_gid[34] !== 1) begin
                nerr++; $display("FAIL maxb_rotate: got g%0d,g%0d want g1,g1", obs_gid[16], obs_gid[34]); end
        end
    endtask

    task automatic test_backpressure();
        int seq = 100;
        int rdy1_hi = 0;
        add_burst(0, 5, seq);
        build_expected();
        run_traffic(200, 1, -1);
        nvec++; if (obs_data.size() !== 5) begin
            nerr++; $display("FAIL bp_count: got %0d want 5", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            nvec++; if (obs_data[i] !== exp_data[i]) begin
                nerr++; $display("FAIL bp_beat[%0d]: got %h want %h", i, obs_data[i], exp_data[i]); end
        end
        foreach (log_rdy1[i]) if (log_rdy1[i] !== 1'b0) rdy1_hi++;
        nvec++; if (rdy1_hi !== 0) begin
            nerr++; $display("FAIL bp_rdy1: got %0d cycles high want 0", rdy1_hi); end
    endtask

    task automatic test_cfg_deferral();
        int seq = 200;
        int a, b;
        add_burst(0, 4, seq);
        add_burst(1, 4, seq);
        build_expected();
        cfg_div = 6'd4; cfg_start = 6'd0; cfg_end = 6'd2;
        run_traffic(300, 0, 2);
        nvec++; if (obs_data.size() !== 8) begin
            nerr++; $display("FAIL cfgd_count: got %0d want 8", obs_data.size()); end
        if (obs_data.size() == 8) begin
            a = obs_cyc[3];
            b = obs_cyc[4];
            nvec++; if (log_busy[3] !== 1'b1 || log_busy[a] !== 1'b1) begin
                nerr++; $display("FAIL cfgd_busy_burst: got %b%b want 11", log_busy[3], log_busy[a]); end
            nvec++; if (log_cfg[a] !== {6'd8, 6'd0, 6'd4}) begin
                nerr++; $display("FAIL cfgd_old: got %h want %h", log_cfg[a], {6'd8, 6'd0, 6'd4}); end
            nvec++; if (log_cfg[b] !== {6'd4, 6'd0, 6'd2} || log_busy[b] !== 1'b0) begin
                nerr++; $display("FAIL cfgd_new: got %h busy %b want %h busy 0",
                                 log_cfg[b], log_busy[b], {6'd4, 6'd0, 6'd2}); end
            nvec++; if (b - a !== 12) begin
                nerr++; $display("FAIL cfgd_gap: got %0d want 12", b - a); end
        end
    endtask

    task automatic test_invalid_cfg();
        cfg_div = 6'd1; cfg_start = 6'd0; cfg_end = 6'd0; cfg_update = 1'b1;
        @(posedge clk); #1;
        cfg_update = 1'b0;
        @(negedge clk);
        nvec++; if ({cfg_busy, cfg_err} !== 2'b10) begin
            nerr++; $display("FAIL inv_pending: got %b want 10", {cfg_busy, cfg_err}); end
        @(posedge clk); #1;
        // This cycle is the CFG cycle: a second update here must stay pending.
        cfg_div = 6'd6; cfg_start = 6'd1; cfg_end = 6'd3; cfg_update = 1'b1;
        @(posedge clk); #1;
        cfg_update = 1'b0;
        @(negedge clk);
        nvec++; if ({cfg_busy, cfg_err} !== 2'b11) begin
            nerr++; $display("FAIL inv_err: got %b want 11", {cfg_busy, cfg_err}); end
        nvec++; if ({phy_div, phy_start, phy_end} !== {6'd4, 6'd0, 6'd2}) begin
            nerr++; $display("FAIL inv_keep: got %0d/%0d/%0d want 4/0/2", phy_div, phy_start, phy_end); end
        repeat (12) @(posedge clk);
        @(negedge clk);
        nvec++; if ({phy_div, phy_start, phy_end} !== {6'd6, 6'd1, 6'd3} || cfg_busy !== 1'b0) begin
            nerr++; $display("FAIL inv_second: got %0d/%0d/%0d busy %b want 6/1/3 busy 0",
                             phy_div, phy_start, phy_end, cfg_busy); end
        nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL inv_sticky: got %b want 1", cfg_err); end
        cfg_err_clr = 1'b1;
        @(posedge clk); #1;
        cfg_err_clr = 1'b0;
        nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL inv_clr: got %b want 0", cfg_err); end
        // shift_start == shift_end is illegal; clear held high loses to the set.
        cfg_div = 6'd3; cfg_start = 6'd1; cfg_end = 6'd1; cfg_update = 1'b1; cfg_err_clr = 1'b1;
        @(posedge clk); #1;
        cfg_update = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (cfg_err !== 1'b1) begin nerr++; $display("FAIL inv_setwins: got %b want 1", cfg_err); end
        @(posedge clk); #1;
        nvec++; if (cfg_err !== 1'b0) begin nerr++; $display("FAIL inv_clr2: got %b want 0", cfg_err); end
        cfg_err_clr = 1'b0;
        nvec++; if ({phy_div, phy_start, phy_end} !== {6'd6, 6'd1, 6'd3}) begin
            nerr++; $display("FAIL inv_keep2: got %0d/%0d/%0d want 6/1/3", phy_div, phy_start, phy_end); end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int seq = 300;
        for (int b = 0; b < 4; b++) begin
            add_burst(0, $urandom_range(1, 20), seq);
            add_burst(1, $urandom_range(1, 20), seq);
        end
        build_expected();
        run_traffic(3000, 2, -1);
        nvec++; if (obs_data.size() !== exp_data.size()) begin
            nerr++; $display("FAIL rnd_count: got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            nvec++; if (obs_data[i] !== exp_data[i] || obs_gid[i] !== exp_gid[i]) begin
                nerr++; $display("FAIL rnd_beat[%0d]: got %h/g%0d want %h/g%0d",
                                 i, obs_data[i], obs_gid[i], exp_data[i], exp_gid[i]); end
            if (i > 0 && exp_first[i]) begin
                nvec++; if (obs_cyc[i] - obs_cyc[i-1] < 6) begin
                    nerr++; $display("FAIL rnd_gap[%0d]: got %0d want >=6", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_mid_reset();
        req_valid = 2'b01; req_data[0] = 16'h1234; req_last = 2'b00; phy_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        nvec++; if (phy_valid !== 1'b1 || phy_data !== 16'h1234) begin
            nerr++; $display("FAIL mr_send: got %b/%h want 1/1234", phy_valid, phy_data); end
        rst_n = 1'b0;
        #1;
        nvec++; if (phy_valid !== 1'b0 || req_ready !== 2'b00) begin
            nerr++; $display("FAIL mr_async: got %b/%b want 0/00", phy_valid, req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        @(posedge clk); #1;
        nvec++; if ({phy_div, phy_start, phy_end} !== {6'd8, 6'd0, 6'd4}) begin
            nerr++; $display("FAIL mr_cfg: got %0d/%0d/%0d want 8/0/4", phy_div, phy_start, phy_end); end
        req_valid = 2'b11; req_data[0] = 16'haaaa; req_data[1] = 16'hbbbb;
        @(posedge clk); #1;
        @(negedge clk);
        nvec++; if (grant_id !== 1'b0 || phy_data !== 16'haaaa) begin
            nerr++; $display("FAIL mr_ptr: got g%0d/%h want g0/aaaa", grant_id, phy_data); end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_max_burst();
        test_backpressure();
        test_cfg_deferral();
        test_invalid_cfg();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
